// File: rtl/hb_interp_pkg.sv
// Shared constants, FSM encoding and the 1s17 halfband coefficient set for the
// interpolating halfband FIR.
package hb_interp_pkg;

  localparam int NTAPS  = 11;
  localparam int DATA_W = 18;
  localparam int COEF_W = 18;
  localparam int ACC_W  = 40;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  // Only the first (NTAPS+1)/2 coefficients are needed; the rest mirror them.
  function automatic logic signed [COEF_W-1:0] coef(input int k);
    case (k)
      0, 10:   return 18'sd1966;
      2, 8:    return -18'sd9830;
      4, 6:    return 18'sd39322;
      5:       return 18'sd65536;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/hb_mac_unit.sv
// Symmetric pre-add, single multiplier and accumulator; acc updates one cycle
// after en, clr has priority over en.
module hb_mac_unit #(
  parameter int DATA_W = 18,
  parameter int COEF_W = 18,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [COEF_W-1:0] c,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [DATA_W:0]        pre;
  logic signed [DATA_W+COEF_W:0] prod;

  always_comb begin
    pre  = $signed({a[DATA_W-1], a}) + $signed({b[DATA_W-1], b});
    prod = pre * c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/halfband_interp_fir.sv
// Interpolating halfband FIR, one shared multiplier, y_valid P+3 clk after an
// accepted int_clk; strobes while busy are dropped and set sticky overrun.
// Optional macro HB_INTERP_SAT_EN: saturate instead of wrap on width reduction.
module halfband_interp_fir #(
  parameter int NTAPS  = hb_interp_pkg::NTAPS,
  parameter int DATA_W = hb_interp_pkg::DATA_W,
  parameter int COEF_W = hb_interp_pkg::COEF_W,
  parameter int ACC_W  = hb_interp_pkg::ACC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     int_clk,
  input  logic signed [DATA_W-1:0] x_in,
  output logic signed [DATA_W-1:0] y,
  output logic                     y_valid,
  output logic                     overrun
);

  import hb_interp_pkg::*;

  localparam int P  = (NTAPS - 1) / 2;
  localparam int KW = $clog2(P + 1);

  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

  state_t                    state;
  logic [KW-1:0]             k;
  logic signed [DATA_W-1:0]  d [NTAPS];
  logic signed [DATA_W-1:0]  op_a;
  logic signed [DATA_W-1:0]  op_b;
  logic signed [COEF_W-1:0]  op_c;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   sh;
  logic signed [DATA_W-1:0]  y_next;
  logic                      accept;

  assign accept = (state == IDLE) && int_clk;

  // Centre tap reuses the pair datapath with a zero partner.
  always_comb begin
    op_a = d[0];
    op_b = '0;
    op_c = '0;
    for (int i = 0; i <= P; i++) begin
      if (k == KW'(i)) begin
        op_a = d[i];
        op_b = (i < P) ? d[NTAPS-1-i] : '0;
        op_c = coef(i);
      end
    end
  end

  hb_mac_unit #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (state == MAC),
    .a     (op_a),
    .b     (op_b),
    .c     (op_c),
    .acc   (acc)
  );

  assign sh = acc >>> (COEF_W - 1);

`ifdef HB_INTERP_SAT_EN
  always_comb begin
    if (sh > Y_MAX) begin
      y_next = Y_MAX[DATA_W-1:0];
    end else if (sh < Y_MIN) begin
      y_next = Y_MIN[DATA_W-1:0];
    end else begin
      y_next = sh[DATA_W-1:0];
    end
  end
`else
  logic unused_sh;
  assign unused_sh = ^{sh[ACC_W-1:DATA_W], Y_MAX, Y_MIN};
  assign y_next    = sh[DATA_W-1:0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      k       <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      overrun <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        d[i] <= '0;
      end
    end else begin
      y_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (int_clk) begin
            d[0] <= x_in;
            for (int i = 1; i < NTAPS; i++) begin
              d[i] <= d[i-1];
            end
            k     <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          if (int_clk) begin
            overrun <= 1'b1;
          end
          if (k == KW'(P)) begin
            state <= OUT;
          end else begin
            k <= k + KW'(1);
          end
        end
        OUT: begin
          if (int_clk) begin
            overrun <= 1'b1;
          end
          y       <= y_next;
          y_valid <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
